// File: rtl/program_loader.sv
// Boot-time copy engine: streams a program image out of the BIOS ROM into
// instruction RAM, then flips changeSource so fetch moves from BIOS to RAM.
module program_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] progLength,
  output logic [DATA_WIDTH-1:0] biosAddress,
  input  logic [DATA_WIDTH-1:0] biosData,
  output logic [ADDR_WIDTH-1:0] ramAddress,
  output logic [DATA_WIDTH-1:0] ramData,
  output logic                  ramWrite,
  output logic                  busy,
  output logic                  done,
  output logic                  changeSource,
  output logic [DATA_WIDTH-1:0] checksum,
  output logic [2:0]            state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_CAPTURE = 3'd2,
    S_WRITE   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] idx, idx_nxt;
  logic [ADDR_WIDTH-1:0] len, len_nxt;
  logic [ADDR_WIDTH-1:0] idx_inc;
  logic [DATA_WIDTH-1:0] bios_addr_nxt;
  logic [ADDR_WIDTH-1:0] ram_addr_nxt;
  logic [DATA_WIDTH-1:0] ram_data_nxt;
  logic                  ram_wr_nxt;
  logic                  busy_nxt;
  logic                  done_nxt;
  logic                  chg_src_nxt;
  logic [DATA_WIDTH-1:0] checksum_nxt;

  assign state_dbg = state;
  // Length is capped at 2^ADDR_WIDTH-1, so idx+1 never wraps.
  assign idx_inc   = idx + ADDR_WIDTH'(1);

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      idx          <= '0;
      len          <= '0;
      biosAddress  <= '0;
      ramAddress   <= '0;
      ramData      <= '0;
      ramWrite     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      changeSource <= 1'b0;
      checksum     <= '0;
    end else begin
      state        <= state_nxt;
      idx          <= idx_nxt;
      len          <= len_nxt;
      biosAddress  <= bios_addr_nxt;
      ramAddress   <= ram_addr_nxt;
      ramData      <= ram_data_nxt;
      ramWrite     <= ram_wr_nxt;
      busy         <= busy_nxt;
      done         <= done_nxt;
      changeSource <= chg_src_nxt;
      checksum     <= checksum_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    len_nxt       = len;
    bios_addr_nxt = biosAddress;
    ram_addr_nxt  = ramAddress;
    ram_data_nxt  = ramData;
    ram_wr_nxt    = 1'b0;
    busy_nxt      = busy;
    done_nxt      = done;
    chg_src_nxt   = changeSource;
    checksum_nxt  = checksum;

    case (state)
      // DONE restarts exactly like IDLE; start is ignored in the busy states.
      S_IDLE, S_DONE: begin
        if (start) begin
          checksum_nxt = '0;
          if (progLength != '0) begin
            len_nxt       = progLength;
            idx_nxt       = '0;
            bios_addr_nxt = '0;
            busy_nxt      = 1'b1;
            done_nxt      = 1'b0;
            chg_src_nxt   = 1'b0;
            state_nxt     = S_READ;
          end else begin
            done_nxt    = 1'b1;
            chg_src_nxt = 1'b1;
            state_nxt   = S_DONE;
          end
        end
      end
      S_READ: begin
        state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        ram_data_nxt = biosData;
        ram_addr_nxt = idx;
        checksum_nxt = checksum ^ biosData;
        ram_wr_nxt   = 1'b1;
        state_nxt    = S_WRITE;
      end
      S_WRITE: begin
        if (idx == len - ADDR_WIDTH'(1)) begin
          busy_nxt    = 1'b0;
          done_nxt    = 1'b1;
          chg_src_nxt = 1'b1;
          state_nxt   = S_DONE;
        end else begin
          idx_nxt       = idx_inc;
          bios_addr_nxt = DATA_WIDTH'(idx_inc);
          state_nxt     = S_READ;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a registered BIOS model, a write monitor,
// a table of copy runs and hand-written reset/restart sequences.
module tb_program_loader;

  logic        clock;
  logic        rst;
  logic        start;
  logic [9:0]  progLength;
  logic [31:0] biosAddress;
  logic [31:0] biosData;
  logic [9:0]  ramAddress;
  logic [31:0] ramData;
  logic        ramWrite;
  logic        busy;
  logic        done;
  logic        changeSource;
  logic [31:0] checksum;
  logic [2:0]  state_dbg;

  logic [31:0] bios_mem [16];
  logic [41:0] exp_q[$];
  logic [41:0] got_q[$];
  int          consec_cnt;
  logic        prev_wr;
  int          n_cmp;
  int          n_fail;

  typedef struct {
    int          len;
    int          poke;
    logic [31:0] chk;
  } vec_t;

  vec_t vecs [7];

  program_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
    .clock        (clock),
    .rst          (rst),
    .start        (start),
    .progLength   (progLength),
    .biosAddress  (biosAddress),
    .biosData     (biosData),
    .ramAddress   (ramAddress),
    .ramData      (ramData),
    .ramWrite     (ramWrite),
    .busy         (busy),
    .done         (done),
    .changeSource (changeSource),
    .checksum     (checksum),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // BIOS ROM with a registered read port on the same clock
  initial biosData = '0;
  always @(posedge clock) biosData <= bios_mem[biosAddress[3:0]];

  // RAM write monitor
  initial begin
    consec_cnt = 0;
    prev_wr    = 1'b0;
  end
  always @(negedge clock) begin
    if (ramWrite) begin
      got_q.push_back({ramAddress, ramData});
      if (prev_wr) consec_cnt <= consec_cnt + 1;
    end
    prev_wr <= ramWrite;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One complete copy of len words; poke>=0 pulses start (length 5) mid-copy.
  task automatic run_copy(input int len, input int poke, input logic [31:0] exp_chk);
    int base;
    int c0;
    int cyc;
    logic [41:0] e;
    base = got_q.size();
    c0   = consec_cnt;
    exp_q.delete();
    for (int k = 0; k < len; k++) exp_q.push_back({10'(k), bios_mem[k]});

    @(negedge clock);
    start      = 1'b1;
    progLength = 10'(len);
    @(posedge clock);
    #1;
    start      = 1'b0;
    progLength = 10'd7;
    check("busy_after_e0", 64'(busy), 64'(len != 0));
    check("done_after_e0", 64'(done), 64'(len == 0));
    check("chsrc_after_e0", 64'(changeSource), 64'(len == 0));

    cyc = 0;
    while (!done && cyc < 200) begin
      @(posedge clock);
      #1;
      cyc++;
      if (cyc == poke) begin
        start      = 1'b1;
        progLength = 10'd5;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;

    check("done_cycle", 64'(cyc), 64'(3 * len));
    check("busy_at_done", 64'(busy), 64'd0);
    check("chsrc_at_done", 64'(changeSource), 64'd1);
    check("checksum", 64'(checksum), 64'(exp_chk));
    check("write_count", 64'(got_q.size() - base), 64'(len));
    for (int i = base; i < got_q.size(); i++) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 42'h3ff_ffff_ffff;
      check("write_addr_data", 64'(got_q[i]), 64'(e));
    end
    check("write_pulse_single", 64'(consec_cnt - c0), 64'd0);

    @(posedge clock);
    #1;
    check("done_hold", 64'(done), 64'd1);
    check("checksum_hold", 64'(checksum), 64'(exp_chk));
    check("state_done", 64'(state_dbg), 64'd4);
  endtask

  initial begin
    int base;
    n_cmp  = 0;
    n_fail = 0;
    rst        = 1'b0;
    start      = 1'b0;
    progLength = '0;
    bios_mem[0] = 32'h0000_0000;
    bios_mem[1] = 32'h3800_0002;
    bios_mem[2] = 32'h3001_0000;
    bios_mem[3] = 32'h0000_00ff;
    bios_mem[4] = 32'h1234_5678;
    for (int i = 5; i < 16; i++) bios_mem[i] = 32'(i) * 32'h0101_0101;

    vecs[0] = '{len: 3, poke: -1, chk: 32'h0801_0002};
    vecs[1] = '{len: 0, poke: -1, chk: 32'h0000_0000};
    vecs[2] = '{len: 2, poke: -1, chk: 32'h3800_0002};
    vecs[3] = '{len: 3, poke: 2,  chk: 32'h0801_0002};
    vecs[4] = '{len: 5, poke: -1, chk: 32'h1a35_5685};
    vecs[5] = '{len: 1, poke: -1, chk: 32'h0000_0000};
    vecs[6] = '{len: 4, poke: -1, chk: 32'h0801_00fd};

    // Mid-cycle reset with no clock edge
    #2;
    rst = 1'b1;
    #1;
    check("reset_outputs", 64'({biosAddress, ramAddress, ramData, ramWrite, busy, done,
                                changeSource, checksum} != '0), 64'd0);
    check("reset_state", 64'(state_dbg), 64'd0);
    @(negedge clock);
    rst = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("idle_after_reset", 64'(state_dbg), 64'd0);
    check("busy_after_reset", 64'(busy), 64'd0);

    for (int v = 0; v < 7; v++) run_copy(vecs[v].len, vecs[v].poke, vecs[v].chk);

    // Reset at E0+4 of a 3-word copy: only word 0 reaches RAM
    base = got_q.size();
    @(negedge clock);
    start      = 1'b1;
    progLength = 10'd3;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    rst = 1'b1;
    #1;
    check("midcopy_reset_outputs", 64'({biosAddress, ramAddress, ramData, ramWrite, busy, done,
                                       changeSource, checksum} != '0), 64'd0);
    check("midcopy_chsrc", 64'(changeSource), 64'd0);
    check("midcopy_write_count", 64'(got_q.size() - base), 64'd1);
    if (got_q.size() > base)
      check("midcopy_word0", 64'(got_q[base]), 64'({10'd0, bios_mem[0]}));
    @(negedge clock);
    rst = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("midcopy_idle", 64'(state_dbg), 64'd0);

    run_copy(3, -1, 32'h0801_0002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time copy engine that reads a program image out of the BIOS ROM one word at a time and writes it into instruction RAM. Once the copy completes, it asserts `changeSource` so the fetch path switches from BIOS to RAM. It drives the BIOS read port (address out, registered data back) and the RAM write port. It sits between the BIOS, the instruction RAM and the PC/fetch mux.

## Interface
- `DATA_WIDTH`, 32, instruction word width; also the width of the BIOS address bus.
- `ADDR_WIDTH`, 10, instruction-RAM address width.
- `clock`  in  1  single clock for the block. The BIOS read port must be clocked by this same clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a copy; sampled on rising `clock`.
- `progLength`  in  ADDR_WIDTH  number of words to copy, sampled with `start`.
- `biosAddress`  out  DATA_WIDTH  BIOS word address; registered, zero-extended index.
- `biosData`  in  DATA_WIDTH  BIOS `instOut`; valid one clock after `biosAddress` changes.
- `ramAddress`  out  ADDR_WIDTH  RAM write address; registered.
- `ramData`  out  DATA_WIDTH  RAM write data; registered.
- `ramWrite`  out  1  RAM write enable; high for one cycle per word.
- `busy`  out  1  copy in progress.
- `done`  out  1  last copy has finished.
- `changeSource`  out  1  fetch from RAM instead of BIOS.
- `checksum`  out  DATA_WIDTH  running XOR of all words written in the current/last copy.

## Operation
- **Reset values.** All outputs are 0 and the state is IDLE.
- **State machine.** States are IDLE, READ, CAPTURE, WRITE, DONE. A word index register (ADDR_WIDTH bits) and a latched length register are kept internally.
- **IDLE**
  - `start`=1 and `progLength`≠0:
    - latch the length;
    - index←0, `biosAddress`←0, `checksum`←0;
    - `busy`←1, `done`←0, `changeSource`←0;
    - go to READ.
  - `start`=1 and `progLength`=0: `checksum`←0, `done`←1, `changeSource`←1, go to DONE.
- **READ.** The BIOS samples `biosAddress` at this edge. Go to CAPTURE.
- **CAPTURE** (`biosData` is valid):
  - `ramData`←`biosData`;
  - `ramAddress`←index;
  - `checksum`←`checksum`^`biosData`;
  - `ramWrite`←1;
  - go to WRITE.
- **WRITE** (`ramWrite`=1 for this cycle only):
  - `ramWrite`←0.
  - If index = length−1: `busy`←0, `done`←1, `changeSource`←1, go to DONE.
  - Otherwise: index←index+1, `biosAddress`←index+1, go to READ.
- **DONE.** `done` and `changeSource` hold.
  - `start`=1 restarts exactly as from IDLE: `done` and `changeSource` drop to 0 for the whole new copy.
  - `start`=0: stay in DONE.
- **`start` while busy** (READ/CAPTURE/WRITE) is ignored. Changes to `progLength` while busy are ignored.
- **Maximum length** is 2^ADDR_WIDTH−1 words. The index never wraps.
- **`rst` mid-copy**
  - Immediately forces all outputs to 0 and the state to IDLE; `ramWrite` deasserts asynchronously.
  - RAM keeps whatever was already written; there is no rollback.
  - `changeSource`=0, so fetch returns to the BIOS.

## Timing
- **Reference edge.** E0 is the edge that samples `start`=1.
- **Copy length.** A copy of N words takes 3N cycles. `busy` is 1 from after E0 until after edge E0+3N. `done` and `changeSource` rise after edge E0+3N.
- **Per-word schedule for word k:**
  - `biosAddress`=k after edge E0+3k;
  - `biosData`=mem[k] after E0+3k+1;
  - `ramWrite`=1, with `ramAddress`=k and `ramData`=mem[k], during the cycle after E0+3k+2;
  - the RAM captures the word at E0+3k+3.
- **Checksum.** `checksum` includes word k from edge E0+3k+2 onward. The final value is stable while in DONE.
- **Zero length.** A `start` with length 0 raises `done`/`changeSource` after E0 and never asserts `ramWrite`.
- **Write pulse.** `ramWrite` is never high for two consecutive cycles.

## Test plan
- **Reset.** Assert `rst` mid-cycle → all outputs 0 immediately, with no clock edge required. Deassert → the block remains in IDLE.
- **3-word copy.** BIOS holds mem[0..2] = 00000000, 38000002, 30010000; `progLength`=3, pulse `start`.
  - Exactly 3 `ramWrite` pulses, at addresses 0, 1, 2 with the matching data.
  - `done`=1 after edge E0+9.
  - `checksum`=08010002.
- **Zero length.** `progLength`=0 with `start` → `done`=1 and `changeSource`=1 one cycle later; no `ramWrite`; `checksum`=0.
- **Start while busy.** Pulse `start` again with `progLength`=5 during a 3-word copy → ignored; still exactly 3 writes, done at E0+9.
- **Reset mid-copy.** Assert `rst` at E0+4 of the 3-word copy → only word 0 has been written; `changeSource`=0. A later `start` recopies from address 0.
- **Restart from DONE.** After a completed copy, pulse `start` with `progLength`=2 → `done` and `changeSource` drop, 2 writes occur, and both rise again after E0+6.
